// File: rtl/mem_burst_read_2d.sv
// 2-D region burst read master (Avalon-MM) feeding an internal show-ahead FIFO.
// Optional macro MBR2D_ABORT_EN adds control_abort with a discard/flush drain path.
module mem_burst_read_2d #(
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int ADDRESSWIDTH    = 30,
    parameter int FIFODEPTH       = 64,
    parameter int FIFODEPTH_LOG2  = 6,
    parameter int MAXBURST        = 8,
    parameter int BURSTWIDTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDRESSWIDTH-1:0]    control_read_base,
    input  logic [ADDRESSWIDTH-1:0]    control_line_length,
    input  logic [ADDRESSWIDTH-1:0]    control_stride,
    input  logic [15:0]                control_line_count,
    input  logic                       control_go,
`ifdef MBR2D_ABORT_EN
    input  logic                       control_abort,
`endif
    output logic                       control_busy,
    output logic                       control_done,
    input  logic                       user_read_buffer,
    output logic [DATAWIDTH-1:0]       user_buffer_data,
    output logic                       user_data_available,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_read,
    output logic [BURSTWIDTH-1:0]      master_burstcount,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    input  logic [DATAWIDTH-1:0]       master_readdata,
    input  logic                       master_readdatavalid,
    input  logic                       master_waitrequest
);
    localparam int BESHIFT = $clog2(BYTEENABLEWIDTH);
    localparam int PW      = FIFODEPTH_LOG2 + 1;
    localparam int CW      = FIFODEPTH_LOG2 + 3;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                    state_reg;
    logic [ADDRESSWIDTH-1:0]   addr_reg, line_addr_reg, stride_reg, len_words_reg, words_left_reg;
    logic [15:0]               lines_left_reg;
    logic                      read_reg, busy_reg, done_reg, discard_reg;
    logic [BURSTWIDTH-1:0]     burst_reg;
    logic [PW-1:0]             pending_reg, pending_next;
    logic [PW-1:0]             fifo_used_reg;
    logic [FIFODEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [DATAWIDTH-1:0]      fifo_mem [FIFODEPTH];

    logic                      accept, hold, frame_end, credit_ok, abort_hit, push, pop;
    logic [ADDRESSWIDTH-1:0]   wl_after, addr_after, line_after;
    logic [15:0]               lines_after;
    logic [BURSTWIDTH-1:0]     next_burst;
    logic [CW-1:0]             credit_sum;

`ifdef MBR2D_ABORT_EN
    logic abort_pend_reg;
    assign abort_hit = control_abort | abort_pend_reg;
`else
    assign abort_hit = 1'b0;
`endif

    // Pointer state after this cycle's accept, and the burst that would follow it.
    always_comb begin
        accept      = read_reg & ~master_waitrequest;
        hold        = read_reg & master_waitrequest;
        wl_after    = words_left_reg;
        addr_after  = addr_reg;
        line_after  = line_addr_reg;
        lines_after = lines_left_reg;
        frame_end   = 1'b0;
        if (accept) begin
            wl_after   = words_left_reg - ADDRESSWIDTH'(burst_reg);
            addr_after = addr_reg + (ADDRESSWIDTH'(burst_reg) << BESHIFT);
            if (wl_after == '0) begin
                if (lines_left_reg > 16'd1) begin
                    line_after  = line_addr_reg + stride_reg;
                    addr_after  = line_after;
                    wl_after    = len_words_reg;
                    lines_after = lines_left_reg - 16'd1;
                end else begin
                    frame_end = 1'b1;
                end
            end
        end
        next_burst = (wl_after >= ADDRESSWIDTH'(MAXBURST)) ? BURSTWIDTH'(MAXBURST)
                                                           : BURSTWIDTH'(wl_after);
        // Count the burst being accepted right now, since pending has not absorbed it yet.
        credit_sum = CW'(fifo_used_reg) + CW'(pending_reg)
                   + (accept ? CW'(burst_reg) : CW'(0)) + CW'(next_burst);
        credit_ok  = (credit_sum <= CW'(FIFODEPTH));
        pending_next = pending_reg + (accept ? PW'(burst_reg) : PW'(0))
                     - PW'(master_readdatavalid);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            line_addr_reg  <= '0;
            stride_reg     <= '0;
            len_words_reg  <= '0;
            words_left_reg <= '0;
            lines_left_reg <= '0;
            read_reg       <= 1'b0;
            burst_reg      <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            discard_reg    <= 1'b0;
            pending_reg    <= '0;
`ifdef MBR2D_ABORT_EN
            abort_pend_reg <= 1'b0;
`endif
        end else begin
            done_reg    <= 1'b0;
            pending_reg <= pending_next;
            case (state_reg)
                IDLE: begin
                    if (control_go) begin
                        addr_reg       <= control_read_base;
                        line_addr_reg  <= control_read_base;
                        stride_reg     <= control_stride;
                        len_words_reg  <= control_line_length >> BESHIFT;
                        words_left_reg <= control_line_length >> BESHIFT;
                        lines_left_reg <= control_line_count;
`ifdef MBR2D_ABORT_EN
                        abort_pend_reg <= 1'b0;
`endif
                        if (control_line_count == 16'd0) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= ISSUE;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!hold) begin
                        addr_reg       <= addr_after;
                        line_addr_reg  <= line_after;
                        words_left_reg <= wl_after;
                        lines_left_reg <= lines_after;
                        if (frame_end || abort_hit) begin
                            read_reg    <= 1'b0;
                            discard_reg <= abort_hit;
                            state_reg   <= DRAIN;
                        end else begin
                            read_reg  <= credit_ok;
                            burst_reg <= next_burst;
                        end
                    end
`ifdef MBR2D_ABORT_EN
                    else if (control_abort) begin
                        abort_pend_reg <= 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (pending_reg == '0) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    done_reg    <= 1'b1;
                    discard_reg <= 1'b0;
                    state_reg   <= IDLE;
`ifdef MBR2D_ABORT_EN
                    abort_pend_reg <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign push = master_readdatavalid & ~discard_reg;
    assign pop  = user_read_buffer & (fifo_used_reg != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= master_readdata;
        end
    end

    // An aborted frame keeps the FIFO flushed until its drain finishes.
    always_ff @(posedge clk) begin
        if (!reset_n || discard_reg) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            fifo_used_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            fifo_used_reg <= fifo_used_reg + PW'(push) - PW'(pop);
        end
    end

    assign user_buffer_data    = fifo_mem[rd_ptr_reg];
    assign user_data_available = (fifo_used_reg != '0);
    assign master_address      = addr_reg;
    assign master_read         = read_reg;
    assign master_burstcount   = burst_reg;
    assign master_byteenable   = '1;
    assign control_busy        = busy_reg;
    assign control_done        = done_reg;
endmodule
